mt_cycle_monitor: RTL

- Downstream consumer of the AGC top-level timing outputs MT01..MT12 and MGOJAM, clocked by the fast simulation/FPGA clock.
- Synchronises the timepulses and checks that they run in strict cyclic order.
- Counts completed memory cycle times (MCTs), counts GOJAM events, and flags sequence and stall errors for bench checking and FPGA status LEDs.

---
 rtl/mt_mon_pkg.sv | 8 +
 rtl/mt_sync_edge.sv | 29 ++
 rtl/mt_cycle_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mt_mon_pkg.sv
// mt_mon_pkg: shared state encoding, timepulse count and phase wrap helper
package mt_mon_pkg;
  localparam int NUM_MT = 12;
  typedef enum logic [1:0] {S_WAIT, S_LOCK, S_GOJAM} state_e;
  function automatic logic [3:0] next_phase(input logic [3:0] p);
    return (p == 4'(NUM_MT)) ? 4'd1 : p + 4'd1;
  endfunction
endpackage

// File: rtl/mt_sync_edge.sv
// mt_sync_edge: multi-flop synchroniser with rise/fall detection for one async bit
module mt_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q, hist_d;
  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, d});
    hist_d = sync;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~hist_q;
  assign fall = ~sync & hist_q;
endmodule

// File: rtl/mt_cycle_monitor.sv
// mt_cycle_monitor: tracks AGC timepulse order, counts MCTs and GOJAMs, flags sequence/stall errors
module mt_cycle_monitor
  import mt_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 32
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST_n,
  input  logic             MT01,
  input  logic             MT02,
  input  logic             MT03,
  input  logic             MT04,
  input  logic             MT05,
  input  logic             MT06,
  input  logic             MT07,
  input  logic             MT08,
  input  logic             MT09,
  input  logic             MT10,
  input  logic             MT11,
  input  logic             MT12,
  input  logic             MGOJAM,
  input  logic             clr_err,
  output logic             locked,
  output logic [3:0]       phase,
  output logic             mct_strobe,
  output logic [CNT_W-1:0] mct_count,
  output logic             seq_err,
  output logic             stall_err,
  output logic [7:0]       err_count,
  output logic [7:0]       gojam_count
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  logic [NUM_MT:0] raw, sync, rise, fall;
  logic [NUM_MT-1:0] mt_sync, mt_rise, exp_vec;
  logic gj_rise, gj_fall, unused_bits;
  logic [3:0] exp_p;
  logic seq_ev, stall_ev, err_ev;
  state_e state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic strobe_q, strobe_d, seq_q, seq_d, stall_q, stall_d;
  logic [CNT_W-1:0] mct_q, mct_d;
  logic [7:0] err_q, err_d, gj_q, gj_d;
  assign raw = {MGOJAM, MT12, MT11, MT10, MT09, MT08, MT07, MT06, MT05, MT04, MT03, MT02, MT01};
  for (genvar i = 0; i <= NUM_MT; i++) begin : g_sync
    mt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (SIM_CLK),
      .rst_n(SIM_RST_n),
      .d    (raw[i]),
      .sync (sync[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
  assign mt_sync     = sync[NUM_MT-1:0];
  assign mt_rise     = rise[NUM_MT-1:0];
  assign gj_rise     = rise[NUM_MT];
  assign gj_fall     = fall[NUM_MT];
  assign unused_bits = ^{fall[NUM_MT-1:0], sync[NUM_MT]};
  assign exp_p       = next_phase(phase_q);
  assign exp_vec     = NUM_MT'(1) << (exp_p - 4'd1);
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    wd_d     = '0;
    strobe_d = 1'b0;
    mct_d    = mct_q;
    gj_d     = gj_q;
    seq_ev   = 1'b0;
    stall_ev = 1'b0;
    if (gj_rise) begin
      state_d = S_GOJAM;
      phase_d = '0;
      gj_d    = (gj_q == 8'hFF) ? gj_q : gj_q + 8'd1;
    end else begin
      case (state_q)
        S_WAIT: if (mt_rise[0]) begin
          state_d = S_LOCK;
          phase_d = 4'd1;
        end
        S_LOCK: begin
          // any unexpected, multiple or overlapping pulse breaks lock
          seq_ev   = (|mt_rise && mt_rise != exp_vec) || |(mt_sync & (mt_sync - NUM_MT'(1)));
          stall_ev = !seq_ev && !(|mt_rise) && wd_q == WD_MAX;
          if (seq_ev || stall_ev) begin
            state_d = S_WAIT;
            phase_d = '0;
          end else if (|mt_rise) begin
            phase_d  = exp_p;
            strobe_d = exp_p == 4'(NUM_MT);
            mct_d    = (strobe_d && mct_q != '1) ? mct_q + CNT_W'(1) : mct_q;
          end else wd_d = wd_q + WD_W'(1);
        end
        S_GOJAM: state_d = gj_fall ? S_WAIT : S_GOJAM;
        default: state_d = S_WAIT;
      endcase
    end
    err_ev  = seq_ev | stall_ev;
    seq_d   = (seq_q & ~clr_err) | seq_ev;
    stall_d = (stall_q & ~clr_err) | stall_ev;
    err_d   = clr_err ? {7'd0, err_ev} : (err_ev && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge SIM_CLK or negedge SIM_RST_n)
    if (!SIM_RST_n) begin
      state_q  <= S_WAIT;
      phase_q  <= '0;
      wd_q     <= '0;
      strobe_q <= 1'b0;
      mct_q    <= '0;
      seq_q    <= 1'b0;
      stall_q  <= 1'b0;
      err_q    <= '0;
      gj_q     <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      wd_q     <= wd_d;
      strobe_q <= strobe_d;
      mct_q    <= mct_d;
      seq_q    <= seq_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      gj_q     <= gj_d;
    end
  assign locked      = state_q == S_LOCK;
  assign phase       = phase_q;
  assign mct_strobe  = strobe_q;
  assign mct_count   = mct_q;
  assign seq_err     = seq_q;
  assign stall_err   = stall_q;
  assign err_count   = err_q;
  assign gojam_count = gj_q;
endmodule
